// File: rtl/junction_pkg.sv
// Shared types and default timing for the junction phase scheduler.
package junction_pkg;

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } state_t;

  typedef logic [1:0] approach_t;

  localparam int DEF_MIN_GREEN = 3;
  localparam int DEF_MAX_GREEN = 6;
  localparam int DEF_YELLOW_T  = 2;
  localparam int DEF_ALLRED_T  = 1;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin next-grant search: first pending approach starting at phase+1.
module rr_pick
  import junction_pkg::*;
(
  input  logic [3:0] pending,
  input  approach_t  phase,
  output approach_t  grant,
  output logic       valid
);

  approach_t cand;

  // grant is meaningful only while valid=1; valid=1 exactly when any pending bit is set.
  always_comb begin
    grant = phase;
    valid = 1'b0;
    cand  = phase;
    // Scan from farthest to nearest so the nearest hit overwrites the rest.
    for (int k = 4; k >= 1; k--) begin
      cand = phase + 2'(k);
      if (pending[cand]) begin
        grant = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/junction_phase_scheduler.sv
// Four-approach traffic phase scheduler (ALLRED/GREEN/YELLOW) with round-robin grants.
// Optional emergency preemption is enabled by defining PREEMPT_EN.
module junction_phase_scheduler
  import junction_pkg::*;
#(
  parameter int MIN_GREEN = DEF_MIN_GREEN,
  parameter int MAX_GREEN = DEF_MAX_GREEN,
  parameter int YELLOW_T  = DEF_YELLOW_T,
  parameter int ALLRED_T  = DEF_ALLRED_T
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] req,
`ifdef PREEMPT_EN
  input  logic       preempt,
  input  approach_t  preempt_id,
`endif
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic [3:0] red,
  output approach_t  phase,
  output logic [3:0] pending,
  output state_t     dbg_state
);

  localparam int TW = $clog2(max_of(max_of(MIN_GREEN, MAX_GREEN),
                                    max_of(YELLOW_T, ALLRED_T)) + 1);
  localparam logic [TW-1:0] T_MIN    = TW'(MIN_GREEN);
  localparam logic [TW-1:0] T_MAX    = TW'(MAX_GREEN);
  localparam logic [TW-1:0] T_YELLOW = TW'(YELLOW_T);
  localparam logic [TW-1:0] T_ALLRED = TW'(ALLRED_T);

  state_t        state, state_n;
  approach_t     phase_n;
  logic [TW-1:0] timer;
  logic          granting;
  logic [3:0]    grant_mask, other;
  logic [3:0]    green_n, yellow_n, red_n;
  approach_t     pick_idx;
  logic          pick_valid;
  logic          max_out, gap_out;
  logic          pre_on;
  approach_t     pre_id;

`ifdef PREEMPT_EN
  assign pre_on = preempt;
  assign pre_id = preempt_id;
`else
  assign pre_on = 1'b0;
  assign pre_id = 2'd0;
`endif

  rr_pick u_rr_pick (
    .pending (pending),
    .phase   (phase),
    .grant   (pick_idx),
    .valid   (pick_valid)
  );

  assign other      = pending & ~(4'b0001 << phase);
  assign max_out    = (timer >= T_MAX);
  assign gap_out    = (timer >= T_MIN) && !req[phase];
  assign grant_mask = granting ? (4'b0001 << phase_n) : 4'b0000;
  assign dbg_state  = state;

  always_comb begin
    state_n  = state;
    phase_n  = phase;
    granting = 1'b0;
    case (state)
      ALLRED: begin
        if (timer >= T_ALLRED) begin
          if (pre_on) begin
            state_n  = GREEN;
            phase_n  = pre_id;
            granting = 1'b1;
          end else if (pick_valid) begin
            state_n  = GREEN;
            phase_n  = pick_idx;
            granting = 1'b1;
          end
        end
      end
      GREEN: begin
        // Preemption cuts a foreign green short but holds the preempting approach.
        if (pre_on) begin
          if (pre_id != phase) state_n = YELLOW;
        end else if ((other != 4'b0000) && (max_out || gap_out)) begin
          state_n = YELLOW;
        end
      end
      YELLOW: begin
        if (timer >= T_YELLOW) state_n = ALLRED;
      end
      default: state_n = ALLRED;
    endcase
  end

  // Lamps decode the registered state, so they trail each state change by one cycle.
  always_comb begin
    green_n  = 4'b0000;
    yellow_n = 4'b0000;
    red_n    = 4'b1111;
    if (state == GREEN) begin
      green_n[phase] = 1'b1;
      red_n[phase]   = 1'b0;
    end else if (state == YELLOW) begin
      yellow_n[phase] = 1'b1;
      red_n[phase]    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ALLRED;
      timer   <= '0;
      phase   <= 2'd3;
      pending <= 4'b0000;
      green   <= 4'b0000;
      yellow  <= 4'b0000;
      red     <= 4'b1111;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      pending <= (pending | req) & ~grant_mask;
      if (state_n != state) begin
        timer <= '0;
      end else if (tick && (timer != '1)) begin
        timer <= timer + 1'b1;
      end
      green   <= green_n;
      yellow  <= yellow_n;
      red     <= red_n;
    end
  end

endmodule

// File: tb/tb_junction_phase_scheduler.sv
// Directed self-checking bench for junction_phase_scheduler (tick every 4 clk, default timing).
module tb_junction_phase_scheduler;
  import junction_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [3:0] req = 4'b0000;
`ifdef PREEMPT_EN
  logic       preempt = 1'b0;
  approach_t  preempt_id = 2'd0;
`endif
  logic [3:0] green, yellow, red, pending;
  approach_t  phase;
  state_t     dbg_state;

  int n_pass = 0;
  int n_total = 0;
  int tick_div = 0;
  int tick_seen = 0;

  junction_phase_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .req        (req),
`ifdef PREEMPT_EN
    .preempt    (preempt),
    .preempt_id (preempt_id),
`endif
    .green      (green),
    .yellow     (yellow),
    .red        (red),
    .phase      (phase),
    .pending    (pending),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset / tick ----------------
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      tick_div = (tick_div + 1) % 4;
      tick = (tick_div == 0);
    end
  end

  always @(posedge clk) if (tick) tick_seen++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_lamps(input logic [3:0] g, input logic [3:0] y, input int budget,
                            output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (green === g && yellow === y) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_tick_count(input int target);
    for (int i = 0; i < 16; i++) begin
      if (tick_seen >= target) break;
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'b1111;
    repeat (3) @(negedge clk);
    n_total++; if (red !== 4'b1111) $display("FAIL reset_red: got %b want 1111", red); else n_pass++;
    n_total++; if (green !== 4'b0000) $display("FAIL reset_green: got %b want 0000", green); else n_pass++;
    n_total++; if (yellow !== 4'b0000) $display("FAIL reset_yellow: got %b want 0000", yellow); else n_pass++;
    n_total++; if (phase !== 2'd3) $display("FAIL reset_phase: got %0d want 3", phase); else n_pass++;
    n_total++; if (pending !== 4'b0000) $display("FAIL reset_pending: got %b want 0000", pending); else n_pass++;
    n_total++; if (dbg_state !== ALLRED) $display("FAIL reset_state: got %0d want %0d", dbg_state, ALLRED); else n_pass++;
    req = 4'b0000;
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int greens = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (green !== 4'b0000) greens++;
    end
    n_total++; if (greens != 0) $display("FAIL idle_no_green: got %0d green cycles want 0", greens); else n_pass++;
    n_total++; if (red !== 4'b1111) $display("FAIL idle_red: got %b want 1111", red); else n_pass++;
    n_total++; if (phase !== 2'd3) $display("FAIL idle_phase: got %0d want 3", phase); else n_pass++;
  endtask

  task automatic test_single_request();
    bit ok;
    int n0, held_bad;
    do_reset();
    n0 = tick_seen;
    req = 4'b0001;
    @(negedge clk);
    req = 4'b0000;
    wait_lamps(4'b0001, 4'b0000, 100, ok);
    n_total++; if (!ok || (tick_seen - n0) != 1)
      $display("FAIL single_first_green: got %0d ticks (reached=%0b) want 1", tick_seen - n0, ok); else n_pass++;
    held_bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (green !== 4'b0001) held_bad++;
    end
    n_total++; if (held_bad != 0) $display("FAIL single_rest_green: got %0d off cycles want 0", held_bad); else n_pass++;
    n_total++; if (pending !== 4'b0000) $display("FAIL single_pending: got %b want 0000", pending); else n_pass++;
    n_total++; if (phase !== 2'd0) $display("FAIL single_phase: got %0d want 0", phase); else n_pass++;
  endtask

  task automatic test_max_out();
    bit ok;
    int n0, n1, n2, n3;
    do_reset();
    req = 4'b0001;
    wait_lamps(4'b0001, 4'b0000, 100, ok);
    n_total++; if (!ok) $display("FAIL maxout_green0: got green %b want 0001", green); else n_pass++;
    n0 = tick_seen;
    wait_tick_count(n0 + 1);
    req = 4'b0101;
    @(negedge clk);
    req = 4'b0001;
    wait_lamps(4'b0000, 4'b0001, 200, ok);
    n1 = tick_seen;
    n_total++; if (!ok || (n1 - n0) != 6)
      $display("FAIL maxout_green_len: got %0d ticks (reached=%0b) want 6", n1 - n0, ok); else n_pass++;
    wait_lamps(4'b0000, 4'b0000, 100, ok);
    n2 = tick_seen;
    n_total++; if (!ok || (n2 - n1) != 2)
      $display("FAIL maxout_yellow_len: got %0d ticks (reached=%0b) want 2", n2 - n1, ok); else n_pass++;
    wait_lamps(4'b0100, 4'b0000, 100, ok);
    n3 = tick_seen;
    n_total++; if (!ok || (n3 - n2) != 1)
      $display("FAIL maxout_allred_len: got %0d ticks (reached=%0b) want 1", n3 - n2, ok); else n_pass++;
    n_total++; if (phase !== 2'd2) $display("FAIL maxout_phase: got %0d want 2", phase); else n_pass++;
    req = 4'b0000;
  endtask

  task automatic test_gap_out();
    bit ok;
    int n0, n1;
    do_reset();
    req = 4'b0011;
    @(negedge clk);
    req = 4'b0001;
    wait_lamps(4'b0001, 4'b0000, 100, ok);
    n0 = tick_seen;
    wait_tick_count(n0 + 1);
    req = 4'b0000;
    wait_lamps(4'b0000, 4'b0001, 200, ok);
    n1 = tick_seen;
    n_total++; if (!ok || (n1 - n0) != 3)
      $display("FAIL gapout_green_len: got %0d ticks (reached=%0b) want 3", n1 - n0, ok); else n_pass++;
    wait_lamps(4'b0010, 4'b0000, 200, ok);
    n_total++; if (!ok) $display("FAIL gapout_next_green: got green %b want 0010", green); else n_pass++;
    n_total++; if (phase !== 2'd1) $display("FAIL gapout_phase: got %0d want 1", phase); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_q[$];
    logic [3:0] last_g;
    logic [1:0] got_idx, exp_idx;
    int bad_lamps, grants;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    req = 4'b1111;
    last_g = 4'b0000;
    bad_lamps = 0;
    grants = 0;
    for (int i = 0; i < 1000 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      if (((green | yellow | red) !== 4'b1111) || ((green & yellow) !== 4'b0000) ||
          ((green & red) !== 4'b0000) || ((yellow & red) !== 4'b0000) || ($countones(~red) > 1))
        bad_lamps++;
      if (last_g === 4'b0000 && green !== 4'b0000) begin
        got_idx = 2'd0;
        for (int b = 0; b < 4; b++) if (green[b]) got_idx = 2'(b);
        exp_idx = exp_q.pop_front();
        grants++;
        n_total++; if (got_idx !== exp_idx)
          $display("FAIL rr_order_%0d: got approach %0d want %0d", grants, got_idx, exp_idx); else n_pass++;
      end
      last_g = green;
    end
    n_total++; if (grants != 5) $display("FAIL rr_grant_count: got %0d want 5", grants); else n_pass++;
    n_total++; if (bad_lamps != 0) $display("FAIL rr_lamp_exclusive: got %0d bad cycles want 0", bad_lamps); else n_pass++;
    req = 4'b0000;
  endtask

  task automatic test_reset_mid_phase();
    bit ok;
    int n0;
    do_reset();
    req = 4'b0001;
    wait_lamps(4'b0001, 4'b0000, 100, ok);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_total++; if (red !== 4'b1111) $display("FAIL midreset_red_async: got %b want 1111", red); else n_pass++;
    n_total++; if (green !== 4'b0000) $display("FAIL midreset_green_async: got %b want 0000", green); else n_pass++;
    repeat (2) @(negedge clk);
    n_total++; if (pending !== 4'b0000) $display("FAIL midreset_pending: got %b want 0000", pending); else n_pass++;
    rst = 1'b0;
    n0 = tick_seen;
    wait_lamps(4'b0001, 4'b0000, 100, ok);
    n_total++; if (!ok || (tick_seen - n0) != 1)
      $display("FAIL midreset_clearance: got %0d ticks (reached=%0b) want 1", tick_seen - n0, ok); else n_pass++;
    req = 4'b0000;
  endtask

`ifdef PREEMPT_EN
  task automatic test_preempt();
    bit ok;
    int n0, n1;
    do_reset();
    req = 4'b0010;
    @(negedge clk);
    req = 4'b0000;
    wait_lamps(4'b0010, 4'b0000, 100, ok);
    n0 = tick_seen;
    wait_tick_count(n0 + 1);
    preempt = 1'b1;
    preempt_id = 2'd3;
    repeat (2) @(negedge clk);
    n_total++; if (yellow !== 4'b0010) $display("FAIL preempt_yellow: got %b want 0010", yellow); else n_pass++;
    n1 = tick_seen;
    wait_lamps(4'b1000, 4'b0000, 100, ok);
    n_total++; if (!ok || (tick_seen - n1) != 3)
      $display("FAIL preempt_to_green3: got %0d ticks (reached=%0b) want 3", tick_seen - n1, ok); else n_pass++;
    preempt = 1'b0;
    req = 4'b0001;
    @(negedge clk);
    req = 4'b0000;
    wait_lamps(4'b0000, 4'b1000, 200, ok);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_total++; if (red !== 4'b1111) $display("FAIL preempt_reset_red: got %b want 1111", red); else n_pass++;
    n_total++; if (yellow !== 4'b0000) $display("FAIL preempt_reset_yellow: got %b want 0000", yellow); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_idle();
    test_single_request();
    test_max_out();
    test_gap_out();
    test_round_robin();
    test_reset_mid_phase();
`ifdef PREEMPT_EN
    test_preempt();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
